// File: rtl/cce_deadlock_watchdog.sv
// cce_deadlock_watchdog: filters HLS deadlock-monitor block bits and latches a sticky deadlock report
//
// Ports:
//   clock        core clock
//   reset        asynchronous active-low reset
//   mon_block    raw block bits from the deadlock monitors
//   mon_enable   per-monitor mask, 1 = monitor considered
//   threshold    consecutive high cycles required (0 behaves as 1)
//   irq_ack      software acknowledge, honoured only while reporting
//   clear        synchronous clear of report, counters and FSM
//   deadlock     sticky detected flag
//   irq          level interrupt, held until acknowledged
//   first_idx    lowest enabled blocking monitor at detection
//   stall_cycles saturating stall duration since detection
//   event_count  saturating number of detections
//   det_time     detection timestamp
//
// Optional feature: define CCE_DL_TIMESTAMP_EN to build a 32-bit free-running
// cycle counter whose value is captured into det_time on each detection;
// otherwise det_time is tied to 0.
module cce_deadlock_watchdog #(
    parameter int NUM_MON  = 4,
    parameter int THRESH_W = 16,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
    input  logic [NUM_MON-1:0]  mon_enable,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                irq_ack,
    input  logic                clear,
    output logic                deadlock,
    output logic                irq,
    output logic [IDX_W-1:0]    first_idx,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    event_count,
    output logic [31:0]         det_time
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WATCH   = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;
    localparam logic [1:0] HOLDOFF = 2'd3;

    logic [1:0]          state;
    logic [THRESH_W-1:0] pcnt;
    logic [NUM_MON-1:0]  blk_en;
    logic                any_blk;
    logic [THRESH_W-1:0] eff_thr;
    logic [THRESH_W:0]   pcnt_nx;
    logic                enter;
    logic [IDX_W-1:0]    low_idx;

    assign blk_en  = mon_block & mon_enable;
    assign any_blk = |blk_en;
    assign eff_thr = (threshold == '0) ? THRESH_W'(1) : threshold;
    assign pcnt_nx = {1'b0, pcnt} + (THRESH_W + 1)'(1);
    // pcnt is 0 in IDLE, so the same compare covers the eff_thr = 1 shortcut;
    // >= also catches a threshold lowered below the running count
    assign enter   = (state == IDLE || state == WATCH) && any_blk && (pcnt_nx >= {1'b0, eff_thr});

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--)
            if (blk_en[i]) low_idx = IDX_W'(i);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pcnt         <= '0;
            deadlock     <= 1'b0;
            irq          <= 1'b0;
            first_idx    <= '0;
            stall_cycles <= '0;
            event_count  <= '0;
        end else if (clear) begin
            state        <= IDLE;
            pcnt         <= '0;
            deadlock     <= 1'b0;
            irq          <= 1'b0;
            first_idx    <= '0;
            stall_cycles <= '0;
            event_count  <= '0;
        end else begin
            case (state)
                IDLE, WATCH: begin
                    if (!any_blk) begin
                        state <= IDLE;
                        pcnt  <= '0;
                    end else if (enter) begin
                        state        <= REPORT;
                        pcnt         <= '0;
                        deadlock     <= 1'b1;
                        irq          <= 1'b1;
                        first_idx    <= low_idx;
                        stall_cycles <= '0;
                        event_count  <= (event_count == '1) ? event_count : event_count + CNT_W'(1);
                    end else begin
                        state <= WATCH;
                        pcnt  <= pcnt_nx[THRESH_W-1:0];
                    end
                end
                REPORT: begin
                    if (any_blk && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
                    if (irq_ack) begin
                        irq   <= 1'b0;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // wait for the stall to clear so the same stall cannot re-trigger
                    if (!any_blk) state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCE_DL_TIMESTAMP_EN
    logic [31:0] ts;

    // free-running; clear only wipes the captured value, not the time base
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts <= '0;
        else ts <= ts + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) det_time <= '0;
        else if (clear) det_time <= '0;
        else if (enter) det_time <= ts;
    end
`else
    assign det_time = '0;
`endif
endmodule

// File: tb/tb_cce_deadlock_watchdog.sv
// tb_cce_deadlock_watchdog: table, directed and randomized checks of cce_deadlock_watchdog
module tb_cce_deadlock_watchdog;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  mon_block = '0;
    logic [3:0]  mon_enable = 4'hF;
    logic [15:0] threshold = 16'd4;
    logic        irq_ack = 1'b0;
    logic        clear = 1'b0;
    logic        deadlock, irq;
    logic [1:0]  first_idx;
    logic [15:0] stall_cycles, event_count;
    logic [31:0] det_time;

    int n_checks = 0;
    int n_errors = 0;

    cce_deadlock_watchdog dut (
        .clock(clock), .reset(reset), .mon_block(mon_block), .mon_enable(mon_enable),
        .threshold(threshold), .irq_ack(irq_ack), .clear(clear), .deadlock(deadlock),
        .irq(irq), .first_idx(first_idx), .stall_cycles(stall_cycles),
        .event_count(event_count), .det_time(det_time)
    );

    always #5 clock = ~clock;

    // reference model: run = consecutive qualifying high cycles while armed
    bit          m_dl, m_irq, m_rep, m_hold;
    int          m_idx, m_stall, m_evt, m_run;
    int unsigned m_det, m_ts;

    task automatic model_reset();
        m_dl = 0; m_irq = 0; m_rep = 0; m_hold = 0;
        m_idx = 0; m_stall = 0; m_evt = 0; m_run = 0; m_det = 0; m_ts = 0;
    endtask

    task automatic model_step();
        bit blk;
        int eff;
        blk = |(mon_block & mon_enable);
        eff = (threshold == 0) ? 1 : int'(threshold);
        if (clear) begin
            m_dl = 0; m_irq = 0; m_rep = 0; m_hold = 0;
            m_idx = 0; m_stall = 0; m_evt = 0; m_run = 0; m_det = 0;
        end else if (m_rep) begin
            if (blk && m_stall < 65535) m_stall++;
            if (irq_ack) begin
                m_irq = 0; m_rep = 0; m_hold = 1;
            end
        end else if (m_hold) begin
            if (!blk) m_hold = 0;
        end else if (!blk) begin
            m_run = 0;
        end else if (m_run + 1 >= eff) begin
            m_run = 0; m_rep = 1; m_dl = 1; m_irq = 1; m_stall = 0;
            if (m_evt < 65535) m_evt++;
            for (int i = 3; i >= 0; i--) if (mon_block[i] && mon_enable[i]) m_idx = i;
`ifdef CCE_DL_TIMESTAMP_EN
            m_det = m_ts;
`endif
        end else begin
            m_run++;
        end
        m_ts++;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model deadlock", deadlock, m_dl);
        chk("model irq", irq, m_irq);
        chk("model first_idx", first_idx, m_idx);
        chk("model stall_cycles", stall_cycles, m_stall);
        chk("model event_count", event_count, m_evt);
        chk("model det_time", det_time, m_det);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset deadlock", deadlock, 0);
        chk("reset irq", irq, 0);
        chk("reset event_count", event_count, 0);
        chk("reset stall_cycles", stall_cycles, 0);
        chk("reset first_idx", first_idx, 0);
        chk("reset det_time", det_time, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  blk;
        logic [15:0] thr;
        logic        ack, clr, dl, irq;
        logic [1:0]  idx;
        logic [15:0] stall, evt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] blk, input int thr, input bit ack, input bit clr,
                       input bit dl, input bit iq, input int idx, input int stall, input int evt);
        vec_t v;
        v.blk = blk; v.thr = 16'(thr); v.ack = ack; v.clr = clr;
        v.dl = dl; v.irq = iq; v.idx = 2'(idx); v.stall = 16'(stall); v.evt = 16'(evt);
        tv.push_back(v);
    endtask

    initial begin
        repeat (3) add(4'b0100, 4, 0, 0, 0, 0, 0, 0, 0);
        add(4'b0000, 4, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) add(4'b1100, 4, 0, 0, 0, 0, 0, 0, 0);
        add(4'b1100, 4, 0, 0, 1, 1, 2, 0, 1);
        for (int k = 1; k <= 9; k++) add(4'b1100, 4, 0, 0, 1, 1, 2, k, 1);
        add(4'b1100, 4, 1, 0, 1, 0, 2, 10, 1);
        repeat (3) add(4'b1100, 4, 0, 0, 1, 0, 2, 10, 1);
        add(4'b0000, 4, 0, 0, 1, 0, 2, 10, 1);
        repeat (3) add(4'b0001, 4, 0, 0, 1, 0, 2, 10, 1);
        add(4'b0001, 4, 0, 0, 1, 1, 0, 0, 2);
        add(4'b0000, 4, 0, 0, 1, 1, 0, 0, 2);
        add(4'b0000, 4, 1, 0, 1, 0, 0, 0, 2);
        add(4'b0000, 4, 0, 0, 1, 0, 0, 0, 2);
        repeat (3) add(4'b0010, 4, 0, 0, 1, 0, 0, 0, 2);
        add(4'b0010, 4, 1, 0, 1, 1, 1, 0, 3);
        add(4'b0000, 4, 0, 0, 1, 1, 1, 0, 3);
        add(4'b0010, 4, 1, 1, 0, 0, 0, 0, 0);
        add(4'b0001, 0, 0, 0, 1, 1, 0, 0, 1);
        add(4'b0000, 0, 1, 0, 1, 0, 0, 0, 1);
        add(4'b0000, 0, 0, 0, 1, 0, 0, 0, 1);

        do_reset();
        foreach (tv[n]) begin
            mon_block = tv[n].blk; mon_enable = 4'hF; threshold = tv[n].thr;
            irq_ack = tv[n].ack; clear = tv[n].clr;
            tick();
            chk($sformatf("vec%0d deadlock", n), deadlock, tv[n].dl);
            chk($sformatf("vec%0d irq", n), irq, tv[n].irq);
            chk($sformatf("vec%0d first_idx", n), first_idx, tv[n].idx);
            chk($sformatf("vec%0d stall_cycles", n), stall_cycles, tv[n].stall);
            chk($sformatf("vec%0d event_count", n), event_count, tv[n].evt);
        end
        irq_ack = 0;

        clear = 1; tick(); clear = 0;
        mon_enable = 4'b1101; mon_block = 4'b0010; threshold = 4;
        repeat (100) tick();
        chk("masked deadlock", deadlock, 0);
        chk("masked event_count", event_count, 0);
        mon_enable = 4'hF; mon_block = 0; tick();

        threshold = 1; mon_block = 4'b0001; tick();
        chk("pre-clear irq", irq, 1);
        clear = 1; tick(); clear = 0;
        chk("clear deadlock", deadlock, 0);
        chk("clear irq", irq, 0);
        chk("clear event_count", event_count, 0);
        mon_block = 0; tick();

        threshold = 4; mon_block = 4'b1000;
        repeat (2) tick();
        do_reset();
        repeat (3) tick();
        chk("post-reset no early detect", deadlock, 0);
        tick();
        chk("post-reset detect", deadlock, 1);
        chk("post-reset first_idx", first_idx, 3);
        chk("post-reset event_count", event_count, 1);

        mon_block = 0; clear = 1; tick(); clear = 0;
        threshold = 10; mon_block = 4'b0001;
        repeat (5) tick();
        chk("thr10 no detect", deadlock, 0);
        threshold = 3; tick();
        chk("thr lowered detect", deadlock, 1);
        mon_block = 0; irq_ack = 1; tick(); irq_ack = 0;

`ifdef CCE_DL_TIMESTAMP_EN
        mon_block = 0; threshold = 1;
        do_reset();
        repeat (57) tick();
        mon_block = 4'b0001; tick();
        chk("det_time at 57", det_time, 57);
        mon_block = 0; irq_ack = 1; tick(); irq_ack = 0;
`endif

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) mon_block = 4'($urandom);
            mon_enable = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 15) == 0) threshold = 16'($urandom_range(0, 6));
            irq_ack = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
